iccm_arb: RTL and testbench

ICCM_ARB -- requirements
Module: iccm_arb

---
 rtl/iccm_arb_pkg.sv | 14 +
 rtl/iccm_arb_if.sv | 50 +++++
 rtl/iccm_arb_tagq.sv | 48 ++++
 rtl/iccm_arb.sv | 112 +++++++++++
 tb/tb_iccm_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/iccm_arb_pkg.sv
// Shared types and default widths for the ICCM arbiter.
package iccm_arb_pkg;

    localparam int unsigned ADDR_W_DEF    = 11;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned TAG_DEPTH_DEF = 4;

    // Owner id stored per outstanding read; routes the returning data.
    typedef enum logic {
        OWN_FE  = 1'b0,
        OWN_DBG = 1'b1
    } own_e;

endpackage

// File: rtl/iccm_arb_if.sv
// Requester- and controller-facing signals of the ICCM arbiter.
// slave: the arbiter side; master: fetch/loader/debug requesters plus the memory controller.
interface iccm_arb_if import iccm_arb_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
);
    logic                  fe_req;
    logic [ADDR_WIDTH-1:0] fe_addr;
    logic                  fe_gnt;
    logic [DATA_WIDTH-1:0] fe_rdata;
    logic                  fe_rvalid;

    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_gnt;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_rvalid;

    logic                  cntlr_rd;
    logic [ADDR_WIDTH-1:0] cntlr_raddr;
    logic [DATA_WIDTH-1:0] cntlr_rd_data;
    logic                  cntlr_rd_valid;
    logic                  cntlr_wr;
    logic [ADDR_WIDTH-1:0] cntlr_waddr;
    logic [DATA_WIDTH-1:0] cntlr_wr_data;

    logic                  rd_err;

    modport slave (
        input  fe_req, fe_addr, ld_req, ld_addr, ld_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, cntlr_rd_data, cntlr_rd_valid,
        output fe_gnt, fe_rdata, fe_rvalid, ld_gnt, dbg_gnt, dbg_rdata, dbg_rvalid,
        output cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, rd_err
    );

    modport master (
        output fe_req, fe_addr, ld_req, ld_addr, ld_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, cntlr_rd_data, cntlr_rd_valid,
        input  fe_gnt, fe_rdata, fe_rvalid, ld_gnt, dbg_gnt, dbg_rdata, dbg_rvalid,
        input  cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, rd_err
    );

endinterface

// File: rtl/iccm_arb_tagq.sv
// Owner-id FIFO tracking outstanding reads, oldest at the head.
// DEPTH must be a power of two so the pointers wrap naturally.
module iccm_arb_tagq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PW + 1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/iccm_arb.sv
// ICCM port arbiter: independent read (fetch/debug) and write (loader/debug) paths.
// Define ICCM_ARB_DBG_EN to let the debug port arbitrate; otherwise it is inert.
module iccm_arb import iccm_arb_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned TAG_DEPTH  = TAG_DEPTH_DEF
) (
    input logic       clk,
    input logic       rst,
    iccm_arb_if.slave bus
);
    logic                  q_full, q_empty, q_head;
    logic                  push, pop, rd_ok;
    logic                  fe_rd_gnt, dbg_rd_gnt, ld_wr_gnt, dbg_wr_gnt;
    own_e                  push_id;
    logic [ADDR_WIDTH-1:0] raddr, waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_err_q;

    // A full queue may still accept a read when a return frees a slot this cycle.
    assign pop   = !rst && bus.cntlr_rd_valid && !q_empty;
    assign rd_ok = !rst && (!q_full || bus.cntlr_rd_valid);

`ifdef ICCM_ARB_DBG_EN
    own_e rr_q, rr_d;
    logic fe_cand, dbg_cand;

    always_comb begin
        fe_cand    = bus.fe_req;
        dbg_cand   = bus.dbg_req && !bus.dbg_we;
        fe_rd_gnt  = rd_ok && fe_cand && (!dbg_cand || rr_q == OWN_FE);
        dbg_rd_gnt = rd_ok && dbg_cand && (!fe_cand || rr_q == OWN_DBG);
        ld_wr_gnt  = !rst && bus.ld_req;
        dbg_wr_gnt = !rst && bus.dbg_req && bus.dbg_we && !bus.ld_req;
        rr_d       = rr_q;
        if (fe_rd_gnt) begin
            rr_d = OWN_DBG;
        end else if (dbg_rd_gnt) begin
            rr_d = OWN_FE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= OWN_FE;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign push_id        = dbg_rd_gnt ? OWN_DBG : OWN_FE;
    assign raddr          = dbg_rd_gnt ? bus.dbg_addr : bus.fe_addr;
    assign waddr          = bus.ld_req ? bus.ld_addr : bus.dbg_addr;
    assign wdata          = bus.ld_req ? bus.ld_wdata : bus.dbg_wdata;
    assign bus.dbg_gnt    = dbg_rd_gnt || dbg_wr_gnt;
    assign bus.dbg_rdata  = bus.cntlr_rd_data;
    assign bus.dbg_rvalid = pop && (q_head == OWN_DBG);
    assign bus.fe_rvalid  = pop && (q_head == OWN_FE);
`else
    logic unused_dbg;

    assign fe_rd_gnt      = rd_ok && bus.fe_req;
    assign dbg_rd_gnt     = 1'b0;
    assign ld_wr_gnt      = !rst && bus.ld_req;
    assign dbg_wr_gnt     = 1'b0;
    assign push_id        = OWN_FE;
    assign raddr          = bus.fe_addr;
    assign waddr          = bus.ld_addr;
    assign wdata          = bus.ld_wdata;
    assign bus.dbg_gnt    = 1'b0;
    assign bus.dbg_rdata  = '0;
    assign bus.dbg_rvalid = 1'b0;
    assign bus.fe_rvalid  = pop;
    assign unused_dbg     = ^{bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata, q_head,
                              dbg_rd_gnt, dbg_wr_gnt};
`endif

    assign push = fe_rd_gnt || dbg_rd_gnt;

    iccm_arb_tagq #(
        .DEPTH (TAG_DEPTH)
    ) u_tagq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_id),
        .pop   (pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // A return with nothing outstanding is dropped and latched as an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else if (bus.cntlr_rd_valid && q_empty) begin
            rd_err_q <= 1'b1;
        end
    end

    assign bus.fe_gnt        = fe_rd_gnt;
    assign bus.fe_rdata      = bus.cntlr_rd_data;
    assign bus.ld_gnt        = ld_wr_gnt;
    assign bus.cntlr_rd      = push;
    assign bus.cntlr_raddr   = raddr;
    assign bus.cntlr_wr      = ld_wr_gnt || dbg_wr_gnt;
    assign bus.cntlr_waddr   = waddr;
    assign bus.cntlr_wr_data = wdata;
    assign bus.rd_err        = rd_err_q;

endmodule

// File: tb/tb_iccm_arb.sv
// Directed self-checking bench for iccm_arb; debug checks follow ICCM_ARB_DBG_EN.
module tb_iccm_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iccm_arb_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

    iccm_arb #(
        .ADDR_WIDTH (11),
        .DATA_WIDTH (32),
        .TAG_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fe_req = 0; bus.fe_addr = '0;
        bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.cntlr_rd_valid = 0; bus.cntlr_rd_data = '0;
    endtask

    initial begin
        idle_inputs();
        // Reset with every request asserted: nothing may be granted.
        bus.fe_req = 1; bus.ld_req = 1; bus.dbg_req = 1; bus.cntlr_rd_valid = 1;
        #3;
        check("rst_fe_gnt", bus.fe_gnt, 0);
        check("rst_ld_gnt", bus.ld_gnt, 0);
        check("rst_dbg_gnt", bus.dbg_gnt, 0);
        check("rst_cntlr_rd", bus.cntlr_rd, 0);
        check("rst_cntlr_wr", bus.cntlr_wr, 0);
        check("rst_fe_rvalid", bus.fe_rvalid, 0);
        check("rst_rd_err", bus.rd_err, 0);
        idle_inputs();
        nxt();
        nxt();
        rst = 0;
        nxt();

`ifdef ICCM_ARB_DBG_EN
        // Fetch and debug reads contend: strict alternation starting with fetch.
        bus.fe_req = 1; bus.fe_addr = 11'h040;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 11'h050;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("alt_fe_gnt", bus.fe_gnt, (k % 2) == 0);
            check("alt_dbg_gnt", bus.dbg_gnt, (k % 2) == 1);
            check("alt_raddr", bus.cntlr_raddr, (k % 2) == 0 ? 11'h040 : 11'h050);
            nxt();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.cntlr_rd_valid = 1; bus.cntlr_rd_data = 32'hc0de_0000 + k;
            @(negedge clk);
            check("alt_fe_rvalid", bus.fe_rvalid, (k % 2) == 0);
            check("alt_dbg_rvalid", bus.dbg_rvalid, (k % 2) == 1);
            check("alt_dbg_rdata", bus.dbg_rdata, 32'hc0de_0000 + k);
            nxt();
        end
        idle_inputs();
        // Loader beats debug write; debug goes next cycle.
        bus.ld_req = 1; bus.ld_addr = 11'h010; bus.ld_wdata = 32'h1111_1111;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 11'h020; bus.dbg_wdata = 32'h2222_2222;
        @(negedge clk);
        check("wr_ld_gnt", bus.ld_gnt, 1);
        check("wr_dbg_gnt0", bus.dbg_gnt, 0);
        check("wr_waddr_ld", bus.cntlr_waddr, 11'h010);
        nxt();
        bus.ld_req = 0;
        @(negedge clk);
        check("wr_dbg_gnt1", bus.dbg_gnt, 1);
        check("wr_waddr_dbg", bus.cntlr_waddr, 11'h020);
        check("wr_wdata_dbg", bus.cntlr_wr_data, 32'h2222_2222);
        nxt();
        idle_inputs();
`else
        // Debug port inert: fetch wins every cycle, debug never granted.
        bus.fe_req = 1; bus.fe_addr = 11'h040;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 11'h050;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("nodbg_fe_gnt", bus.fe_gnt, 1);
            check("nodbg_dbg_gnt", bus.dbg_gnt, 0);
            check("nodbg_raddr", bus.cntlr_raddr, 11'h040);
            nxt();
        end
        bus.fe_req = 0; bus.dbg_we = 1;
        @(negedge clk);
        check("nodbg_wr_gnt", bus.dbg_gnt, 0);
        check("nodbg_cntlr_wr", bus.cntlr_wr, 0);
        nxt();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            bus.cntlr_rd_valid = 1; bus.cntlr_rd_data = 32'hc0de_0000 + k;
            @(negedge clk);
            check("nodbg_fe_rvalid", bus.fe_rvalid, 1);
            check("nodbg_dbg_rvalid", bus.dbg_rvalid, 0);
            check("nodbg_dbg_rdata", bus.dbg_rdata, 0);
            nxt();
        end
        idle_inputs();
`endif

        // Read and write to the same address in one cycle: both issue.
        bus.ld_req = 1; bus.ld_addr = 11'h010; bus.ld_wdata = 32'hdead_beef;
        bus.fe_req = 1; bus.fe_addr = 11'h010;
        @(negedge clk);
        check("rw_ld_gnt", bus.ld_gnt, 1);
        check("rw_cntlr_wr", bus.cntlr_wr, 1);
        check("rw_waddr", bus.cntlr_waddr, 11'h010);
        check("rw_wdata", bus.cntlr_wr_data, 32'hdead_beef);
        check("rw_fe_gnt", bus.fe_gnt, 1);
        check("rw_raddr", bus.cntlr_raddr, 11'h010);
        nxt();
        bus.ld_req = 0;
        for (int k = 1; k < 4; k++) begin
            bus.fe_addr = 11'h010 + 11'(k);
            @(negedge clk);
            check("fill_fe_gnt", bus.fe_gnt, 1);
            check("fill_cntlr_wr", bus.cntlr_wr, 0);
            nxt();
        end
        // Four outstanding: the fifth read stalls until a return frees a slot.
        bus.fe_addr = 11'h014;
        @(negedge clk);
        check("full_fe_gnt", bus.fe_gnt, 0);
        check("full_cntlr_rd", bus.cntlr_rd, 0);
        nxt();
        bus.cntlr_rd_valid = 1; bus.cntlr_rd_data = 32'ha5a5_0001;
        @(negedge clk);
        check("swap_fe_gnt", bus.fe_gnt, 1);
        check("swap_raddr", bus.cntlr_raddr, 11'h014);
        check("swap_fe_rvalid", bus.fe_rvalid, 1);
        check("swap_fe_rdata", bus.fe_rdata, 32'ha5a5_0001);
        nxt();
        bus.cntlr_rd_valid = 0; bus.fe_addr = 11'h015;
        @(negedge clk);
        check("still_full_gnt", bus.fe_gnt, 0);
        nxt();
        bus.fe_req = 0;
        for (int k = 0; k < 4; k++) begin
            bus.cntlr_rd_valid = 1; bus.cntlr_rd_data = 32'h5a5a_0000 + k;
            @(negedge clk);
            check("drain_fe_rvalid", bus.fe_rvalid, 1);
            check("drain_fe_rdata", bus.fe_rdata, 32'h5a5a_0000 + k);
            nxt();
        end
        // Return with nothing outstanding: dropped, sticky error.
        bus.cntlr_rd_data = 32'hbad0_0000;
        @(negedge clk);
        check("orphan_fe_rvalid", bus.fe_rvalid, 0);
        check("orphan_dbg_rvalid", bus.dbg_rvalid, 0);
        check("orphan_err_pre", bus.rd_err, 0);
        nxt();
        bus.cntlr_rd_valid = 0;
        @(negedge clk);
        check("orphan_err_set", bus.rd_err, 1);
        nxt();
        nxt();
        @(negedge clk);
        check("orphan_err_held", bus.rd_err, 1);
        nxt();

        // Two reads outstanding, then an asynchronous reset mid-cycle.
        bus.fe_req = 1; bus.fe_addr = 11'h030;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("pre_rst_fe_gnt", bus.fe_gnt, 1);
            nxt();
        end
        bus.ld_req = 1;
        #2;
        rst = 1;
        #1;
        check("arst_fe_gnt", bus.fe_gnt, 0);
        check("arst_cntlr_rd", bus.cntlr_rd, 0);
        check("arst_ld_gnt", bus.ld_gnt, 0);
        check("arst_cntlr_wr", bus.cntlr_wr, 0);
        check("arst_rd_err", bus.rd_err, 0);
        nxt();
        rst = 0;
        idle_inputs();
        bus.cntlr_rd_valid = 1; bus.cntlr_rd_data = 32'h0000_0042;
        @(negedge clk);
        check("late_fe_rvalid", bus.fe_rvalid, 0);
        nxt();
        bus.cntlr_rd_valid = 0;
        @(negedge clk);
        check("late_rd_err", bus.rd_err, 1);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
